// File: rtl/mips_defs.sv
// mips_defs: shared MIPS datapath constants and helpers.
//   REG_ADDR_W : register index width
//   WORD_W     : datapath word width
//   REG_ZERO   : index of the hardwired-zero register
//   wr_decode  : 5->32 one-hot write enable, never selecting $zero
package mips_defs;

    localparam int          REG_ADDR_W = 5;
    localparam int          WORD_W     = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    // Gated one-hot decode. $zero never gets an enable, so no write can
    // reach it even if the caller forgets to filter index 0.
    function automatic logic [31:0] wr_decode(input logic en, input logic [REG_ADDR_W-1:0] idx);
        logic [31:0] oh;
        oh = '0;
        if (en && idx != REG_ZERO)
            oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux32_1.sv
// mux32_1: 32-to-1 single-bit multiplexer.
//   src : 32 candidate bits (bit n = input n)
//   sel : 5-bit select
//   y   : src[sel]
module mux32_1 (
    input  logic [31:0] src,
    input  logic [4:0]  sel,
    output logic        y
);

    assign y = src[sel];

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit MIPS register file, two combinational read ports,
// one synchronous write port, $zero hardwired to 0.
//   clk, rst_n              : clock, async active-low clear of all registers
//   reg_write               : write enable
//   write_reg, write_data   : write index / value (captured on rising clk)
//   read_reg1, read_reg2    : read indices (rs, rt)
//   read_data1, read_data2  : combinational register contents
// Reads are not bypassed: a same-cycle write shows up only after the edge.
module reg_file
    import mips_defs::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    logic [REG_COUNT-1:0]                  wen;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  rows;   // rows[r] = register r
    logic [DATA_WIDTH-1:0][REG_COUNT-1:0]  slice;  // slice[b][r] = bit b of register r

    assign wen = wr_decode(reg_write, write_reg);

    // $zero is a constant, not a flop.
    assign rows[0] = '0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
        logic [DATA_WIDTH-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (wen[r])
                q <= write_data;
        end
        assign rows[r] = q;
    end

    // Transpose so each bit-slice mux sees bit b of every register.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_slice
        for (genvar r = 0; r < REG_COUNT; r++) begin : g_row
            assign slice[b][r] = rows[r][b];
        end

        mux32_1 u_rd1 (
            .src (slice[b]),
            .sel (read_reg1),
            .y   (read_data1[b])
        );

        mux32_1 u_rd2 (
            .src (slice[b]),
            .sel (read_reg2),
            .y   (read_data2[b])
        );
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    typedef struct {
        string       tag;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected values come from the bench model at stimulus time.
    task automatic push_rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        e.tag = tag;
        e.a1  = a1;
        e.a2  = a2;
        e.e1  = model[a1];
        e.e2  = model[a2];
        sb.push_back(e);
    endtask

    // Apply each queued read, let the combinational path settle, compare.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_reg1 = e.a1;
            read_reg2 = e.a2;
            #1;
            chk($sformatf("%s/p1[%0d]", e.tag, e.a1), read_data1, e.e1);
            chk($sformatf("%s/p2[%0d]", e.tag, e.a2), read_data2, e.e2);
        end
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data, input logic en);
        @(negedge clk);
        reg_write  = en;
        write_reg  = idx;
        write_data = data;
        @(posedge clk);
        #1;
        if (en && idx != 5'd0 && rst_n)
            model[idx] = data;
        reg_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset held, with a write attempt active: everything reads 0.
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) push_rd("rst", 5'(i), 5'(31 - i));
        drain();
        reg_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Write / readback.
        wr(5'd5,  32'h805C_9BD2, 1'b1);
        wr(5'd31, 32'h0000_FFFF, 1'b1);
        push_rd("wb", 5'd5, 5'd31);
        push_rd("wb_nbr", 5'd4, 5'd6);
        drain();

        // $zero writes discarded.
        for (int i = 0; i < 3; i++) begin
            wr(5'd0, 32'hFFFF_FFFF, 1'b1);
            push_rd("zero", 5'd0, 5'd0);
            drain();
        end

        // Write disable.
        wr(5'd7, 32'h1234_5678, 1'b1);
        wr(5'd7, 32'hDEAD_BEEF, 1'b0);
        push_rd("wdis", 5'd7, 5'd7);
        drain();

        // Unknown write controls with reg_write low.
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'bx;
        write_data = 32'bx;
        @(posedge clk);
        #1;
        push_rd("xin", 5'd7, 5'd5);
        drain();

        // Read-during-write: old value before the edge, new after.
        wr(5'd9, 32'h0000_0001, 1'b1);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'hA5A5_A5A5;
        push_rd("rdw_pre", 5'd9, 5'd9);
        drain();
        @(posedge clk);
        model[9] = 32'hA5A5_A5A5;
        #1;
        reg_write = 1'b0;
        push_rd("rdw_post", 5'd9, 5'd9);
        drain();

        // Async reset mid-cycle.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i), 1'b1);
        push_rd("fill", 5'd1, 5'd31);
        push_rd("fill", 5'd16, 5'd17);
        drain();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        push_rd("arst", 5'd1, 5'd31);
        push_rd("arst", 5'd16, 5'd17);
        drain();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) push_rd("arst_post", 5'(i), 5'(31 - i));
        drain();
        wr(5'd12, 32'hCAFE_F00D, 1'b1);
        push_rd("after_rst", 5'd12, 5'd11);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
